// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: I-cache line/word fetch to AXI4 INCR read bridge, one request outstanding. Rev 1.0
// Optional watchdog enabled by defining ICACHE_RD_TIMEOUT_EN.
`default_nettype none

module icache_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID  = 4'h0,
  parameter int         TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rstn,
  // cache side
  input  logic        i_arvalid,
  output logic        i_arready,
  input  logic [31:0] i_araddr,
  input  logic        i_uncache,
  output logic        i_rvalid,
  input  logic        i_rready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rerr,
  // AXI side
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t     state;
  logic       uncached;
  logic [1:0] cnt;

  logic ar_hs;
  logic r_hs;
  logic out_hs;
  logic final_beat;
  logic beat_err;

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("TIMEOUT must be at least 2");
  end

  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign i_arready = (state == IDLE);
  assign rready    = ((state == RD) && (!i_rvalid || i_rready)) || (state == DRAIN);

  assign ar_hs      = arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign out_hs     = i_rvalid && i_rready;
  assign final_beat = uncached || (cnt == 2'd3);
  // AXI rlast is only cross-checked; the beat count alone decides i_rlast.
  assign beat_err   = (rresp != 2'b00) || (rlast != final_beat);

`ifdef ICACHE_RD_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd;
  logic           abandon;
  logic           waiting;

  // After the final beat is loaded, only the cache can stall us, not the slave.
  assign waiting = (state == AR) || ((state == RD) && !(i_rvalid && i_rlast));
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      uncached <= 1'b0;
      cnt      <= 2'd0;
      arvalid  <= 1'b0;
      araddr   <= 32'd0;
      arlen    <= 8'd0;
      i_rvalid <= 1'b0;
      i_rdata  <= 32'd0;
      i_rlast  <= 1'b0;
      i_rerr   <= 1'b0;
`ifdef ICACHE_RD_TIMEOUT_EN
      wd       <= '0;
      abandon  <= 1'b0;
`endif
    end else begin
      if (out_hs) begin
        i_rvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (i_arvalid) begin
            uncached <= i_uncache;
            araddr   <= i_araddr & (i_uncache ? 32'hFFFF_FFFC : 32'hFFFF_FFF0);
            arlen    <= i_uncache ? 8'd0 : 8'd3;
            arvalid  <= 1'b1;
            cnt      <= 2'd0;
            state    <= AR;
          end
        end
        AR: begin
          if (ar_hs) begin
            arvalid <= 1'b0;
            state   <= RD;
          end
        end
        RD: begin
          if (r_hs) begin
            i_rdata  <= rdata;
            i_rvalid <= 1'b1;
            i_rlast  <= final_beat;
            i_rerr   <= beat_err;
            cnt      <= cnt + 2'd1;
            if (final_beat && !rlast) begin
              state <= DRAIN;
            end
          end else if (out_hs && i_rlast) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
`ifdef ICACHE_RD_TIMEOUT_EN
          if (abandon) begin
            // No AR was ever accepted, so no R beats will come to drain.
            if (out_hs) begin
              abandon <= 1'b0;
              state   <= IDLE;
            end
          end else if (r_hs && rlast) begin
            state <= IDLE;
          end
`else
          if (r_hs && rlast) begin
            state <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase

`ifdef ICACHE_RD_TIMEOUT_EN
      if (waiting) begin
        if (ar_hs || r_hs) begin
          wd <= '0;
        end else if (wd == WDW'(TIMEOUT - 1)) begin
          if (!i_rvalid || i_rready) begin
            wd       <= '0;
            i_rdata  <= 32'd0;
            i_rvalid <= 1'b1;
            i_rlast  <= 1'b1;
            i_rerr   <= 1'b1;
            arvalid  <= 1'b0;
            abandon  <= (state == AR);
            state    <= DRAIN;
          end
        end else begin
          wd <= wd + WDW'(1);
        end
      end else begin
        wd <= '0;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: doc/icache_axi_rd_bridge.md
ICACHE_AXI_RD_BRIDGE -- requirements
Module: icache_axi_rd_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0, constant ARID for all requests.
REQ-002 SHALL have parameter TIMEOUT, default 256, idle-cycle limit for the watchdog (see Configuration).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have cache-side ports: i_arvalid in 1 request; i_arready out 1 request accept; i_araddr in 32 request address; i_uncache in 1 single-word request; i_rvalid out 1 beat valid; i_rready in 1 beat accept; i_rdata out 32 beat data; i_rlast out 1 final beat; i_rerr out 1 beat error.
REQ-006 SHALL have AXI-side ports: arid out 4; araddr out 32; arlen out 8; arsize out 3; arburst out 2; arvalid out 1; arready in 1; rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1.

Function
REQ-007 SHALL implement states IDLE, AR, RD, DRAIN; one request outstanding at most.
REQ-008 SHALL drive i_arready=1 only in IDLE.
REQ-009 On i_arvalid&&i_arready SHALL latch address and i_uncache, enter AR next cycle.
REQ-010 SHALL register AR outputs: arvalid=1 throughout AR; araddr = uncached ? {addr[31:2],2'b00} : {addr[31:4],4'h0}.
REQ-011 SHALL drive arlen=8'd0 uncached, 8'd3 cached; arsize=3'b010; arburst=2'b01; arid=AXI_ID.
REQ-012 SHALL hold AR outputs stable until arvalid&&arready, then enter RD; arvalid deasserts the following cycle.
REQ-013 SHALL pass R beats through a one-entry output register: rready = (state==RD) && (!i_rvalid || i_rready).
REQ-014 On rvalid&&rready SHALL load i_rdata=rdata, i_rvalid=1 next cycle (one-cycle latency); i_rerr = (rresp!=2'b00) or beat-count error.
REQ-015 SHALL count accepted beats (2-bit); i_rlast = expected final beat (count 0 uncached, 3 cached), independent of AXI rlast.
REQ-016 AXI rlast early, or missing on expected final beat, SHALL set i_rerr on that delivered beat; on missing rlast, state SHALL go DRAIN.
REQ-017 i_rvalid SHALL clear when i_rready=1 and no new beat loads the same cycle.
REQ-018 Cache handshake on final beat (i_rvalid&&i_rready&&i_rlast) SHALL return state to IDLE next cycle, unless in DRAIN.
REQ-019 DRAIN SHALL hold rready=1, discard beats without forwarding, return to IDLE after AXI beat with rlast=1.
REQ-020 Request handshake in IDLE and final-beat retirement SHALL never coincide (i_arready=0 outside IDLE).

Reset
REQ-021 rstn low SHALL immediately force state IDLE, beat count 0, i_arready=1, and all other outputs 0 except constants arid/arsize/arburst.
REQ-022 Reset mid-transaction SHALL abandon it without draining; AXI slave shares rstn.

Configuration
REQ-023 Macro ICACHE_RD_TIMEOUT_EN defined: counter increments each AR/RD cycle without AR or R handshake, clears on any handshake; on reaching TIMEOUT SHALL deliver one beat i_rdata=0, i_rerr=1, i_rlast=1, then enter DRAIN (AR-state timeout: drop arvalid, go IDLE after delivery).
REQ-024 Macro undefined: no counter logic; bridge waits indefinitely.

Verification
REQ-025 Cached req 0x1C00_0024, arready immediate, 4 beats with rlast on 4th -> araddr 0x1C00_0020, arlen 3, four i_rvalid beats in order, i_rlast only on 4th, i_rerr=0, IDLE after.
REQ-026 Uncached req 0x1FE0_01E6 -> araddr 0x1FE0_01E4, arlen 0, single beat with i_rlast=1.
REQ-027 i_rready held low 3 cycles mid-burst -> rready low, no beat lost/duplicated, data order preserved.
REQ-028 rresp=2'b10 on beat 2 -> that beat i_rerr=1, others 0, burst completes normally.
REQ-029 AXI rlast absent on beat 4, extra beat with rlast on 5th -> beat 4 i_rlast=1 i_rerr=1, beat 5 drained silently, then IDLE.
REQ-030 ICACHE_RD_TIMEOUT_EN, TIMEOUT=16, arready never asserted -> after 16 cycles one beat data 0, i_rerr=1, i_rlast=1; rstn pulse mid-burst -> IDLE, i_rvalid=0 immediately.
